// File: rtl/sqrt_lane_dispatcher.sv
// Round-robin dispatcher/collector for N_LANES compute lanes sharing one argument stream.
// Results are returned strictly in argument order, whatever the per-lane latency.
module sqrt_lane_dispatcher #(
   parameter int N_LANES = 8,
   parameter int WIDTH   = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         arg_vld,
   output logic                         arg_rdy,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   input  logic [WIDTH-1:0]             c,
   output logic                         res_vld,
   input  logic                         res_rdy,
   output logic [WIDTH-1:0]             res,
   output logic [N_LANES-1:0]           lane_arg_vld,
   output logic [N_LANES*WIDTH-1:0]     lane_a,
   output logic [N_LANES*WIDTH-1:0]     lane_b,
   output logic [N_LANES*WIDTH-1:0]     lane_c,
   input  logic [N_LANES-1:0]           lane_res_vld,
   input  logic [N_LANES*WIDTH-1:0]     lane_res,
   output logic [$clog2(N_LANES+1)-1:0] inflight,
   output logic                         err
);

   localparam int PW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam int CW = $clog2(N_LANES+1);
   localparam logic [PW-1:0]      LAST_PTR = PW'(N_LANES-1);
   localparam logic [PW-1:0]      ZERO_PTR = {PW{1'b0}};
   localparam logic [CW-1:0]      ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [N_LANES-1:0] LANE0    = {{(N_LANES-1){1'b0}}, 1'b1};

   logic [PW-1:0]      disp_ptr_r, col_ptr_r;
   logic [N_LANES-1:0] busy_r, full_r, lane_arg_vld_r;
   logic [WIDTH-1:0]   hold_r [N_LANES];
   logic [N_LANES*WIDTH-1:0] lane_a_r, lane_b_r, lane_c_r;
   logic [CW-1:0]      inflight_r;
   logic               err_r;

   logic               accept_s, release_s, arg_rdy_s, res_vld_s;
   logic [WIDTH-1:0]   res_s;
   logic [N_LANES-1:0] disp_oh_s, col_oh_s, capture_s, bad_s, busy_nxt_s, full_nxt_s;

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? ZERO_PTR : p + {{(PW-1){1'b0}}, 1'b1};
   endfunction

   // Handshakes, lane capture/error detection and next busy/full vectors.
   always_comb begin
      arg_rdy_s  = ~busy_r[disp_ptr_r];
      res_vld_s  = full_r[col_ptr_r];
      res_s      = res_vld_s ? hold_r[col_ptr_r] : {WIDTH{1'b0}};
      accept_s   = arg_vld & arg_rdy_s;
      release_s  = res_vld_s & res_rdy;
      disp_oh_s  = LANE0 << disp_ptr_r;
      col_oh_s   = LANE0 << col_ptr_r;
      // A lane may report only while it owns an argument and its hold slot is empty.
      capture_s  = lane_res_vld & busy_r & ~full_r;
      bad_s      = lane_res_vld & (~busy_r | full_r);
      busy_nxt_s = (busy_r | ({N_LANES{accept_s}} & disp_oh_s)) & ~({N_LANES{release_s}} & col_oh_s);
      full_nxt_s = (full_r | capture_s) & ~({N_LANES{release_s}} & col_oh_s);
   end

   // Control state: pointers, lane occupancy, start pulses, occupancy count, sticky error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_ptr_r     <= ZERO_PTR;
         col_ptr_r      <= ZERO_PTR;
         busy_r         <= {N_LANES{1'b0}};
         full_r         <= {N_LANES{1'b0}};
         lane_arg_vld_r <= {N_LANES{1'b0}};
         inflight_r     <= {CW{1'b0}};
         err_r          <= 1'b0;
      end else begin
         disp_ptr_r     <= accept_s ? inc_ptr(disp_ptr_r) : disp_ptr_r;
         col_ptr_r      <= release_s ? inc_ptr(col_ptr_r) : col_ptr_r;
         busy_r         <= busy_nxt_s;
         full_r         <= full_nxt_s;
         lane_arg_vld_r <= accept_s ? disp_oh_s : {N_LANES{1'b0}};
         err_r          <= err_r | (|bad_s);
         case ({accept_s, release_s})
            2'b10:   inflight_r <= inflight_r + ONE_CNT;
            2'b01:   inflight_r <= inflight_r - ONE_CNT;
            default: inflight_r <= inflight_r;
         endcase
      end
   end

   // Datapath: per-lane argument registers and result hold slots.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_a_r <= {(N_LANES*WIDTH){1'b0}};
         lane_b_r <= {(N_LANES*WIDTH){1'b0}};
         lane_c_r <= {(N_LANES*WIDTH){1'b0}};
         for (int i = 0; i < N_LANES; i++) begin
            hold_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (accept_s) begin
            lane_a_r[disp_ptr_r*WIDTH +: WIDTH] <= a;
            lane_b_r[disp_ptr_r*WIDTH +: WIDTH] <= b;
            lane_c_r[disp_ptr_r*WIDTH +: WIDTH] <= c;
         end else begin
            lane_a_r <= lane_a_r;
            lane_b_r <= lane_b_r;
            lane_c_r <= lane_c_r;
         end
         for (int i = 0; i < N_LANES; i++) begin
            hold_r[i] <= capture_s[i] ? lane_res[i*WIDTH +: WIDTH] : hold_r[i];
         end
      end
   end

   assign arg_rdy      = arg_rdy_s;
   assign res_vld      = res_vld_s;
   assign res          = res_s;
   assign lane_arg_vld = lane_arg_vld_r;
   assign lane_a       = lane_a_r;
   assign lane_b       = lane_b_r;
   assign lane_c       = lane_c_r;
   assign inflight     = inflight_r;
   assign err          = err_r;

endmodule

// File: tb/tb_sqrt_lane_dispatcher.sv
// Directed bench for sqrt_lane_dispatcher (8 lanes x 32 bits); lanes are played by the bench.
module tb_sqrt_lane_dispatcher;

   localparam int N = 8;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           arg_vld, arg_rdy, res_vld, res_rdy, err;
   logic [W-1:0]   a, b, c, res;
   logic [N-1:0]   lane_arg_vld, lane_res_vld;
   logic [N*W-1:0] lane_a, lane_b, lane_c, lane_res;
   logic [3:0]     inflight;

   int tests_s = 0;
   int fails_s = 0;

   always #5 clk = ~clk;

   sqrt_lane_dispatcher #(.N_LANES(N), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
      .a(a), .b(b), .c(c), .res_vld(res_vld), .res_rdy(res_rdy), .res(res),
      .lane_arg_vld(lane_arg_vld), .lane_a(lane_a), .lane_b(lane_b), .lane_c(lane_c),
      .lane_res_vld(lane_res_vld), .lane_res(lane_res), .inflight(inflight), .err(err)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_s++;
      if (got !== exp) begin
         fails_s++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle result pulse from lane k carrying value v.
   task automatic lane_pulse(input int k, input logic [W-1:0] v);
      lane_res_vld[k] = 1'b1;
      lane_res[k*W +: W] = v;
      tick();
      lane_res_vld = '0;
   endtask

   initial begin
      rst = 1'b0; arg_vld = 1'b0; res_rdy = 1'b0;
      a = '0; b = '0; c = '0; lane_res_vld = '0; lane_res = '0;
      #1;
      check_eq("rst_arg_rdy", arg_rdy, 1);
      check_eq("rst_res_vld", res_vld, 0);
      check_eq("rst_res", res, 0);
      check_eq("rst_inflight", inflight, 0);
      check_eq("rst_err", err, 0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // In-order basic flow: three args to lanes 0,1,2.
      arg_vld = 1'b1; a = 32'd4; b = 32'd1; c = 32'd2;
      tick();
      check_eq("start0", lane_arg_vld, 8'h01);
      check_eq("lane0_a", lane_a[0*W +: W], 4);
      check_eq("lane0_b", lane_b[0*W +: W], 1);
      check_eq("lane0_c", lane_c[0*W +: W], 2);
      a = 32'd9;
      tick();
      check_eq("start1", lane_arg_vld, 8'h02);
      check_eq("lane1_a", lane_a[1*W +: W], 9);
      check_eq("lane0_a_held", lane_a[0*W +: W], 4);
      a = 32'd16;
      tick();
      check_eq("start2", lane_arg_vld, 8'h04);
      check_eq("inflight3", inflight, 3);
      arg_vld = 1'b0;
      tick();
      check_eq("start_idle", lane_arg_vld, 8'h00);
      tick(); tick(); tick();
      check_eq("no_res_yet", res_vld, 0);
      lane_res_vld = 8'h07;
      lane_res[0*W +: W] = 32'd2; lane_res[1*W +: W] = 32'd3; lane_res[2*W +: W] = 32'd4;
      tick();
      lane_res_vld = '0;
      check_eq("res0_vld", res_vld, 1);
      check_eq("res0", res, 2);
      res_rdy = 1'b1;
      tick();
      check_eq("res1", res, 3);
      tick();
      check_eq("res2", res, 4);
      tick();
      check_eq("drain_vld", res_vld, 0);
      check_eq("drain_inflight", inflight, 0);

      // Out of order: lane4 answers before lane3.
      arg_vld = 1'b1; a = 32'd25;
      tick();
      check_eq("start3", lane_arg_vld, 8'h08);
      a = 32'd36;
      tick();
      check_eq("start4", lane_arg_vld, 8'h10);
      arg_vld = 1'b0;
      lane_pulse(4, 32'd6);
      for (int i = 0; i < 3; i++) begin
         check_eq("ooo_wait", res_vld, 0);
         tick();
      end
      lane_pulse(3, 32'd5);
      check_eq("ooo_first", res, 5);
      check_eq("ooo_first_vld", res_vld, 1);
      tick();
      check_eq("ooo_second", res, 6);
      check_eq("ooo_second_vld", res_vld, 1);
      tick();
      check_eq("ooo_done", res_vld, 0);

      // Protocol error: lane5 reports while idle.
      lane_pulse(5, 32'hdead);
      check_eq("err_set", err, 1);
      check_eq("err_no_res", res_vld, 0);
      check_eq("err_inflight", inflight, 0);

      // Fill all lanes (5,6,7,0..4) with no answers.
      res_rdy = 1'b0; arg_vld = 1'b1;
      for (int i = 0; i < N; i++) begin
         a = 32'd100 + i;
         tick();
      end
      check_eq("full_rdy", arg_rdy, 0);
      check_eq("full_inflight", inflight, 8);
      check_eq("wrap_lane0_a", lane_a[0*W +: W], 103);
      a = 32'd200;
      tick();
      check_eq("full_no_start", lane_arg_vld, 8'h00);
      check_eq("full_inflight2", inflight, 8);
      lane_pulse(5, 32'd50);
      for (int i = 0; i < 10; i++) begin
         check_eq("bp_res", res, 50);
         check_eq("bp_vld", res_vld, 1);
         check_eq("bp_inflight", inflight, 8);
         tick();
      end
      res_rdy = 1'b1;
      tick();
      check_eq("freed_rdy", arg_rdy, 1);
      check_eq("freed_inflight", inflight, 7);
      res_rdy = 1'b0;
      tick();
      check_eq("refill_start", lane_arg_vld, 8'h20);
      check_eq("refill_a", lane_a[5*W +: W], 200);
      check_eq("refill_inflight", inflight, 8);
      arg_vld = 1'b0;

      // Accept and release in the same cycle.
      lane_res_vld = 8'hc0;
      lane_res[6*W +: W] = 32'd60; lane_res[7*W +: W] = 32'd70;
      tick();
      lane_res_vld = '0;
      check_eq("res6", res, 60);
      res_rdy = 1'b1;
      tick();
      check_eq("res7", res, 70);
      check_eq("lane6_free", arg_rdy, 1);
      check_eq("pre_both_inflight", inflight, 7);
      arg_vld = 1'b1; a = 32'd300;
      tick();
      check_eq("both_inflight", inflight, 7);
      check_eq("both_start", lane_arg_vld, 8'h40);
      check_eq("both_a", lane_a[6*W +: W], 300);
      check_eq("err_sticky", err, 1);

      // Mid-operation asynchronous reset.
      res_rdy = 1'b0; a = 32'd400;
      tick();
      check_eq("pre_rst_start", lane_arg_vld, 8'h80);
      rst = 1'b0;
      #1;
      check_eq("mid_rst_rdy", arg_rdy, 1);
      check_eq("mid_rst_vld", res_vld, 0);
      check_eq("mid_rst_inflight", inflight, 0);
      check_eq("mid_rst_start", lane_arg_vld, 8'h00);
      check_eq("mid_rst_err", err, 0);
      check_eq("mid_rst_lane_a", lane_a[6*W +: W], 0);

      $display("[TB] %0d tests run, %0d failed", tests_s, fails_s);
      $finish;
   end

endmodule
